operand_mux_pipe: RTL

Parametrised N-to-1 operand selector with a registered, flow-controlled output stage. It feeds ALU operand ports in the multicycle datapath and replaces fixed-width combinational operand muxes. A dedicated select code forces a zero operand, as used by JR. Other out-of-range codes also yield zero, but are flagged and counted. A two-entry skid buffer decouples producer and consumer at full throughput.

---
 rtl/operand_mux_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/operand_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : operand_mux_pipe
// Description : N-to-1 operand selector feeding an ALU operand port, with a
//               registered two-entry skid buffer on the output. A dedicated
//               select code forces a zero operand (JR); any other code
//               outside the input range also yields zero, is flagged on
//               out_err and counted in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_mux_pipe #(
    parameter int NUM_IN   = 5,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 3,
    parameter int ZERO_SEL = 5,
    parameter int CNT_W    = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        bad_sel_cnt,
    input  logic                    cnt_clr
);

    // State bits are {OR.valid, SK.valid}; 2'b01 is never entered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [SEL_W-1:0] c_zero_sel = SEL_W'(ZERO_SEL);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_or_data;
    logic               r_or_err;
    logic [WIDTH-1:0]   r_sk_data;
    logic               r_sk_err;
    logic [CNT_W-1:0]   r_bad_cnt;

    logic [WIDTH-1:0]   w_in_arr [NUM_IN];
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_hit;
    logic               w_sel_err;

    logic               w_or_valid;
    logic               w_sk_valid;
    logic               w_accept;
    logic               w_xfer;
    logic               w_or_load_in;
    logic               w_or_load_sk;
    logic               w_sk_load;

    // Split the flattened input bus into one word per operand source.
    generate
        for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
            assign w_in_arr[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Operand select: in-range codes pick an input, everything else is zero;
    // only non-ZERO_SEL out-of-range codes are flagged as errors.
    always_comb begin
        w_sel_data = '0;
        w_sel_hit  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = w_in_arr[k];
                w_sel_hit  = 1'b1;
            end
        end
        w_sel_err = !w_sel_hit && (in_sel != c_zero_sel);
    end

    // Handshake terms; in_ready comes straight from the SK valid flop so
    // out_ready never reaches it combinationally.
    assign w_or_valid = r_state[1];
    assign w_sk_valid = r_state[0];
    assign w_accept   = in_valid && !w_sk_valid;
    assign w_xfer     = w_or_valid && out_ready;

    // Next-state and register load enables for the skid buffer.
    always_comb begin
        w_state_nxt  = r_state;
        w_or_load_in = 1'b0;
        w_or_load_sk = 1'b0;
        w_sk_load    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_or_load_in = 1'b1;
                    w_state_nxt  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_xfer) begin
                    w_or_load_in = 1'b1;
                end else if (w_accept) begin
                    w_sk_load   = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_or_load_sk = 1'b1;
                    w_state_nxt  = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register: takes a fresh beat or the parked skid beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_or_data <= '0;
            r_or_err  <= 1'b0;
        end else if (w_or_load_in) begin
            r_or_data <= w_sel_data;
            r_or_err  <= w_sel_err;
        end else if (w_or_load_sk) begin
            r_or_data <= r_sk_data;
            r_or_err  <= r_sk_err;
        end
    end

    // Skid register: parks a beat accepted while the output is stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sk_data <= '0;
            r_sk_err  <= 1'b0;
        end else if (w_sk_load) begin
            r_sk_data <= w_sel_data;
            r_sk_err  <= w_sel_err;
        end
    end

    // Saturating count of accepted illegal-select beats; clear has priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bad_cnt <= '0;
        end else if (cnt_clr) begin
            r_bad_cnt <= '0;
        end else if (w_accept && w_sel_err && (r_bad_cnt != c_cnt_max)) begin
            r_bad_cnt <= r_bad_cnt + 1'b1;
        end
    end

    assign in_ready    = !w_sk_valid;
    assign out_valid   = w_or_valid;
    assign out_data    = r_or_data;
    assign out_err     = r_or_err;
    assign bad_sel_cnt = r_bad_cnt;

endmodule
`default_nettype wire
